// File: rtl/seg_scan_if.sv
// Bus between the display register file (master) and the 7-segment scan driver (slave).
// Carries the content-load strobe and fields plus the registered pin outputs.
interface seg_scan_if;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  brightness;
    logic [3:0]  anode;
    logic [7:0]  cathode;
    logic        frame_done;

    modport master (
        output load, digits, dp, blank, brightness,
        input  anode, cathode, frame_done
    );

    modport slave (
        input  load, digits, dp, blank, brightness,
        output anode, cathode, frame_done
    );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit common-anode 7-segment scan driver with 16-level PWM.
// New content is double-buffered and only swapped in at frame boundaries.
module seg_scan_driver #(
    parameter int PRESCALE = 1563
) (
    input  logic       clk,
    input  logic       reset,
    seg_scan_if.slave  bus
);
    localparam int            PW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    tick_q, tick_d;
    logic [1:0]    digit_q, digit_d;

    logic [15:0] pend_digits_q;
    logic [3:0]  pend_dp_q, pend_blank_q, pend_bright_q;
    logic        pend_vld_q;

    logic [15:0] act_digits_q;
    logic [3:0]  act_dp_q, act_blank_q, act_bright_q;

    logic [3:0]  anode_q, anode_d;
    logic [7:0]  cathode_q, cathode_d;
    logic        frame_done_q;

    logic pcnt_wrap, tick_wrap, boundary, lit;
    logic [3:0] nibble;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        pcnt_wrap = (pcnt_q == PLAST);
        tick_wrap = pcnt_wrap && (tick_q == 4'hF);
        boundary  = tick_wrap && (digit_q == 2'd3);
        pcnt_d    = pcnt_wrap ? '0 : pcnt_q + 1'b1;
        tick_d    = pcnt_wrap ? tick_q + 4'd1 : tick_q;
        digit_d   = tick_wrap ? digit_q + 2'd1 : digit_q;

        // Tick 15 can never satisfy tick < brightness, which gives the anti-ghosting gap.
        nibble    = act_digits_q[{digit_q, 2'b00} +: 4];
        lit       = !act_blank_q[digit_q] && (tick_q < act_bright_q);
        anode_d   = 4'hF;
        cathode_d = 8'hFF;
        if (lit) begin
            anode_d   = ~(4'b0001 << digit_q);
            cathode_d = {~act_dp_q[digit_q], seg7(nibble)};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcnt_q       <= '0;
            tick_q       <= '0;
            digit_q      <= '0;
            pend_vld_q   <= 1'b0;
            act_digits_q <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= 4'hF;
            act_bright_q <= '0;
            anode_q      <= 4'hF;
            cathode_q    <= 8'hFF;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            tick_q       <= tick_d;
            digit_q      <= digit_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            frame_done_q <= boundary;
            // The transfer sees pending as it was before this edge; a same-cycle load waits a frame.
            if (boundary && pend_vld_q) begin
                act_digits_q <= pend_digits_q;
                act_dp_q     <= pend_dp_q;
                act_blank_q  <= pend_blank_q;
                act_bright_q <= pend_bright_q;
            end
            if (bus.load)
                pend_vld_q <= 1'b1;
            else if (boundary)
                pend_vld_q <= 1'b0;
        end
    end

    // Pending content is qualified by pend_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (bus.load) begin
            pend_digits_q <= bus.digits;
            pend_dp_q     <= bus.dp;
            pend_blank_q  <= bus.blank;
            pend_bright_q <= bus.brightness;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.cathode    = cathode_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed and random loads checked every cycle
// against a cycle-count based model of the scan, PWM and frame-boundary rules.
module tb_seg_scan_driver;
    localparam int P  = 2;
    localparam int FR = 64 * P;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    seg_scan_if sif ();

    seg_scan_driver #(.PRESCALE(P)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int n        = 0;

    logic [15:0] a_dig, p_dig;
    logic [3:0]  a_dp, a_bl, a_br, p_dp, p_bl, p_br;
    bit          p_vld;

    logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s at t=%0t n=%0d: observed=%h expected=%h", tag, $time, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        a_dig = '0; a_dp = '0; a_bl = 4'hF; a_br = '0;
        p_vld = 1'b0;
        n     = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_anode"},   {4'h0, sif.anode}, 8'h0F);
        chk({tag, "_cathode"}, sif.cathode,       8'hFF);
        chk({tag, "_fdone"},   {7'h0, sif.frame_done}, 8'h00);
    endtask

    // One clock: predict outputs from the cycle's counters and active content, then check.
    task automatic cycle();
        logic [3:0] ea;
        logic [7:0] ec;
        logic       ef;
        int         tk, dg;
        bit         lit;
        tk  = (n / P) % 16;
        dg  = (n / (16 * P)) % 4;
        lit = (a_bl[dg] == 1'b0) && (tk < int'(a_br));
        ea  = lit ? ~(4'b0001 << dg) : 4'hF;
        ec  = lit ? {~a_dp[dg], SEG[a_dig[dg*4 +: 4]][6:0]} : 8'hFF;
        ef  = ((n % FR) == FR - 1);
        if (ef && p_vld) begin
            a_dig = p_dig; a_dp = p_dp; a_bl = p_bl; a_br = p_br;
            p_vld = 1'b0;
        end
        if (sif.load) begin
            p_dig = sif.digits; p_dp = sif.dp; p_bl = sif.blank; p_br = sif.brightness;
            p_vld = 1'b1;
        end
        n++;
        @(posedge clk);
        #1;
        chk("anode",   {4'h0, sif.anode},      {4'h0, ea});
        chk("cathode", sif.cathode,            ec);
        chk("fdone",   {7'h0, sif.frame_done}, {7'h0, ef});
        sif.load = 1'b0;
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) cycle();
    endtask

    task automatic run_to(input int ph);
        while ((n % FR) != ph) cycle();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dpv,
                           input logic [3:0] bl, input logic [3:0] br);
        sif.digits     = d;
        sif.dp         = dpv;
        sif.blank      = bl;
        sif.brightness = br;
        sif.load       = 1'b1;
        cycle();
    endtask

    task automatic apply_reset(input int hold);
        rst_n    = 1'b0;
        sif.load = 1'b0;
        #1;
        model_reset();
        check_reset("rst_async");
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check_reset("rst_hold");
        end
        rst_n = 1'b1;
        n     = 0;
    endtask

    initial begin
        sif.load = 1'b0; sif.digits = '0; sif.dp = '0; sif.blank = '0; sif.brightness = '0;
        p_dig = '0; p_dp = '0; p_bl = '0; p_br = '0;
        #2;
        apply_reset(2);

        // Dark display with free-running frame pulses, then a reset mid-scan.
        run(2 * FR + 20);
        apply_reset(3);
        run(2 * FR + 10);

        // Full-brightness decode across all 16 hex values.
        do_load(16'h3210, 4'h0, 4'h0, 4'hF);
        run(2 * FR);
        do_load(16'h7654, 4'h0, 4'h0, 4'hF);
        run(2 * FR);
        do_load(16'hBA98, 4'h0, 4'h0, 4'hF);
        run(2 * FR);
        do_load(16'hFEDC, 4'h0, 4'h0, 4'hF);
        run(2 * FR);

        // Partial brightness with one decimal point, then zero brightness.
        do_load(16'h8888, 4'b0010, 4'h0, 4'h4);
        run(2 * FR);
        do_load(16'h8888, 4'b0010, 4'h0, 4'h0);
        run(2 * FR);

        // Blanked digits, then a mid-frame update that must wait for the boundary.
        do_load(16'h1234, 4'h0, 4'b1010, 4'h9);
        run(2 * FR);
        run_to(FR / 2);
        do_load(16'hABCD, 4'hF, 4'h0, 4'hF);
        run(2 * FR);

        // Two loads inside one frame: last one wins.
        run_to(10);
        do_load(16'h1111, 4'h0, 4'h0, 4'h8);
        run(30);
        do_load(16'h5A5A, 4'h5, 4'h0, 4'hC);
        run(2 * FR);

        // Load A, then load B exactly on the boundary cycle.
        run_to(50);
        do_load(16'h0F0F, 4'h1, 4'h0, 4'hF);
        run_to(FR - 1);
        do_load(16'hC3C3, 4'h8, 4'b0100, 4'h6);
        run(2 * FR);

        // Random loads at random points, including occasional boundary hits.
        for (int i = 0; i < 25; i++) begin
            run($urandom_range(0, 300));
            if ($urandom_range(0, 3) == 0) run_to(FR - 1);
            do_load(16'($urandom()), 4'($urandom()), 4'($urandom()), 4'($urandom()));
        end
        run(2 * FR);

        // Reset while a load is pending: pending content must be discarded.
        run_to(10);
        do_load(16'h9999, 4'hF, 4'h0, 4'hF);
        run(20);
        apply_reset(2);
        run(2 * FR + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
